// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator feeding a small result FIFO with ready/valid on both sides.
// Also keeps a saturating count of accepted illegal instructions.
module imm_gen_pipe #(
  parameter int unsigned N        = 64,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned BR_SHIFT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [31:0]  in_instr,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_imm,
  output logic [2:0]   out_fmt,
  output logic         out_illegal,
  input  logic         clr_cnt,
  output logic [7:0]   ill_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_D   = 3'd0,
    FMT_CB  = 3'd1,
    FMT_B   = 3'd2,
    FMT_I   = 3'd3,
    FMT_ILL = 3'd7
  } fmt_e;

  logic [63:0]   dec_ext;
  logic [N-1:0]  dec_imm;
  fmt_e          dec_fmt;
  logic          dec_ill;

  logic [N-1:0]  imm_mem [DEPTH];
  fmt_e          fmt_mem [DEPTH];
  logic          ill_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;

  // Extension is done at 64 bits; shift and truncation to N drop the excess.
  always_comb begin
    dec_ext = '0;
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    if (in_instr[31:21] == 11'h7C2 || in_instr[31:21] == 11'h7C0) begin
      dec_ext = {{55{in_instr[20]}}, in_instr[20:12]};
      dec_fmt = FMT_D;
      dec_ill = 1'b0;
    end else if (in_instr[31:24] == 8'hB4 || in_instr[31:24] == 8'hB5) begin
      dec_ext = {{45{in_instr[23]}}, in_instr[23:5]};
      dec_fmt = FMT_CB;
      dec_ill = 1'b0;
    end else if (in_instr[31:26] == 6'b000101) begin
      dec_ext = {{38{in_instr[25]}}, in_instr[25:0]};
      dec_fmt = FMT_B;
      dec_ill = 1'b0;
    end else if (in_instr[31:22] == 10'b1001000100) begin
      dec_ext = {52'd0, in_instr[21:10]};
      dec_fmt = FMT_I;
      dec_ill = 1'b0;
    end
    if (BR_SHIFT == 1 && (dec_fmt == FMT_CB || dec_fmt == FMT_B)) begin
      dec_ext = dec_ext << 2;
    end
    dec_imm = dec_ext[N-1:0];
  end

  assign out_valid   = (count != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_imm     = imm_mem[rd_ptr];
  assign out_fmt     = fmt_mem[rd_ptr];
  assign out_illegal = ill_mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr] <= dec_imm;
      fmt_mem[wr_ptr] <= dec_fmt;
      ill_mem[wr_ptr] <= dec_ill;
    end
  end

  // in_ready is registered from the next occupancy, so a full buffer
  // refuses a push even in the cycle it is popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      ill_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next != FULL);
      if (clr_cnt)
        ill_count <= '0;
      else if (push && dec_ill && ill_count != 8'hFF)
        ill_count <= ill_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a scoreboard queue holds expected results,
// checked at each negedge against two instances (BR_SHIFT 0 and 1).
module tb_imm_gen_pipe;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        clr_cnt;
  logic        in_ready,    in_ready_sh;
  logic        out_valid,   out_valid_sh;
  logic [63:0] out_imm,     out_imm_sh;
  logic [2:0]  out_fmt,     out_fmt_sh;
  logic        out_illegal, out_illegal_sh;
  logic [7:0]  ill_count,   ill_count_sh;

  always #5 clk = ~clk;

  imm_gen_pipe #(.N(64), .DEPTH(DEPTH), .BR_SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .clr_cnt(clr_cnt), .ill_count(ill_count)
  );

  imm_gen_pipe #(.N(64), .DEPTH(DEPTH), .BR_SHIFT(1)) dut_sh (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready_sh), .out_valid(out_valid_sh), .out_ready(out_ready),
    .out_imm(out_imm_sh), .out_fmt(out_fmt_sh), .out_illegal(out_illegal_sh),
    .clr_cnt(clr_cnt), .ill_count(ill_count_sh)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] imm_sh;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic       m_in_ready;
  logic [7:0] m_ill;
  logic       acc;

  function automatic exp_t mk(input logic [63:0] imm, input logic [63:0] imm_sh,
                              input logic [2:0] fmt, input logic ill);
    exp_t e;
    e.imm = imm; e.imm_sh = imm_sh; e.fmt = fmt; e.ill = ill;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Called at a negedge: check outputs, drive one cycle, update model after the edge.
  task automatic cycle(input logic v, input logic [31:0] instr, input exp_t e,
                       input logic ordy, input logic clr, output logic accepted);
    logic push, pop;
    check("out_valid",    out_valid,    sb.size() != 0);
    check("out_valid_sh", out_valid_sh, sb.size() != 0);
    check("in_ready",     in_ready,     m_in_ready);
    check("in_ready_sh",  in_ready_sh,  m_in_ready);
    check("ill_count",    ill_count,    m_ill);
    if (sb.size() != 0) begin
      check("out_imm",     out_imm,     sb[0].imm);
      check("out_imm_sh",  out_imm_sh,  sb[0].imm_sh);
      check("out_fmt",     out_fmt,     sb[0].fmt);
      check("out_illegal", out_illegal, sb[0].ill);
    end
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    clr_cnt   = clr;
    push = v && m_in_ready;
    pop  = ordy && (sb.size() != 0);
    @(posedge clk);
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(e);
    if (clr) m_ill = 8'd0;
    else if (push && e.ill && m_ill != 8'hFF) m_ill = m_ill + 8'd1;
    m_in_ready = (sb.size() != DEPTH);
    accepted = push;
    @(negedge clk);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 32'h0, '0, ordy, 1'b0, a);
  endtask

  initial begin
    exp_t e_d, e_cb, e_b, e_ill;
    e_d   = mk(64'hFFFFFFFFFFFFFFAA, 64'hFFFFFFFFFFFFFFAA, 3'd0, 1'b0);
    e_cb  = mk(64'hFFFFFFFFFFFFF807, 64'hFFFFFFFFFFFFE01C, 3'd1, 1'b0);
    e_b   = mk(64'h10, 64'h40, 3'd2, 1'b0);
    e_ill = mk(64'h0, 64'h0, 3'd7, 1'b1);

    reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    m_in_ready = 1'b1; m_ill = 8'd0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_ill_count", ill_count, 8'd0);
    reset_n = 1'b1;

    // Single pushes, each observed one cycle later
    cycle(1'b1, 32'hF85AAAAA, e_d, 1'b1, 1'b0, acc);
    idle(1'b1);
    cycle(1'b1, 32'hB4FF00FF, e_cb, 1'b1, 1'b0, acc);
    idle(1'b1);

    // Back-to-back stream with simultaneous push and pop
    cycle(1'b1, 32'h17FFFFFF, mk('1, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h14000010, e_b, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h913FFC00, mk(64'hFFF, 64'hFFF, 3'd3, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hF80FF000, mk(64'hFF, 64'hFF, 3'd0, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hB5000020, mk(64'h1, 64'h4, 3'd1, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hFFFFFFFF, e_ill, 1'b1, 1'b0, acc);
    idle(1'b1);
    check("ill_count_one", ill_count, 8'd1);
    // Clear wins over an illegal push in the same edge
    cycle(1'b1, 32'h00000000, e_ill, 1'b1, 1'b1, acc);
    idle(1'b1);
    check("ill_count_clr", ill_count, 8'd0);

    // Back-pressure: fill, refuse third, refuse again during first pop
    cycle(1'b1, 32'hF85AAAAA, e_d, 1'b0, 1'b0, acc);
    check("acc_first", acc, 1'b1);
    cycle(1'b1, 32'hB4FF00FF, e_cb, 1'b0, 1'b0, acc);
    check("acc_second", acc, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    cycle(1'b1, 32'h14000010, e_b, 1'b0, 1'b0, acc);
    check("acc_third_held", acc, 1'b0);
    cycle(1'b1, 32'h14000010, e_b, 1'b1, 1'b0, acc);
    check("acc_third_on_pop", acc, 1'b0);
    cycle(1'b1, 32'h14000010, e_b, 1'b1, 1'b0, acc);
    check("acc_third_after_pop", acc, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Saturation of the illegal counter
    for (int i = 0; i < 256; i++) cycle(1'b1, 32'hFFFFFFFF, e_ill, 1'b1, 1'b0, acc);
    idle(1'b1);
    check("ill_count_sat", ill_count, 8'hFF);

    // Reset with two entries buffered
    cycle(1'b1, 32'hF85AAAAA, e_d, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hFFFFFFFF, e_ill, 1'b0, 1'b0, acc);
    check("pre_rst_full", in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready",  in_ready,  1'b1);
    check("mid_rst_ill_count", ill_count, 8'd0);
    sb.delete();
    m_in_ready = 1'b1;
    m_ill = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 32'hB4FF00FF, e_cb, 1'b1, 1'b0, acc);
    idle(1'b1);

    for (int i = 0; i < 8 && sb.size() != 0; i++) idle(1'b1);
    check("drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter N, default 64, meaning output immediate width (legal range 32..64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning result buffer entries (power of two, at least 2).
REQ-003 SHALL have parameter BR_SHIFT, default 0, meaning that when 1, CB- and B-type immediates are shifted left by 2 after extension.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning an instruction is offered.
REQ-007 SHALL have port in_instr, input, 32, the LEGv8 instruction word.
REQ-008 SHALL have port in_ready, output, 1, meaning the buffer can accept this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning the buffer head holds a result.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the head this cycle.
REQ-011 SHALL have port out_imm, output, N, the extended immediate.
REQ-012 SHALL have port out_fmt, output, 3, the format code: 0 D, 1 CB, 2 B, 3 I, 7 illegal.
REQ-013 SHALL have port out_illegal, output, 1, set for an unrecognised opcode.
REQ-014 SHALL have port clr_cnt, input, 1, a synchronous clear of ill_count.
REQ-015 SHALL have port ill_count, output, 8, the saturating count of accepted illegal instructions.

Function
REQ-016 SHALL decode D-type when instr[31:21] is 0x7C2 (LDUR) or 0x7C0 (STUR): imm = sign-extend(instr[20:12]), fmt 0.
REQ-017 SHALL decode CB-type when instr[31:24] is 0xB4 (CBZ) or 0xB5 (CBNZ): imm = sign-extend(instr[23:5]), fmt 1.
REQ-018 SHALL decode B-type when instr[31:26] is 6'b000101: imm = sign-extend(instr[25:0]), fmt 2.
REQ-019 SHALL decode I-type when instr[31:22] is 10'b1001000100 (ADDI): imm = zero-extend(instr[21:10]), fmt 3.
REQ-020 SHALL treat every other encoding as illegal: imm 0, fmt 7, out_illegal 1; D, CB, B and I results carry out_illegal 0.
REQ-021 SHALL, when BR_SHIFT=1, shift fmt 1 and fmt 2 results left by 2, with bits beyond N discarded.
REQ-022 SHALL truncate every result to N bits after extension and shift.
REQ-023 SHALL perform a push when in_valid and in_ready are both 1 at a rising edge; the decoded result enters the buffer tail.
REQ-024 SHALL perform a pop when out_valid and out_ready are both 1 at a rising edge; the head advances.
REQ-025 SHALL give a latency of 1 cycle: a result pushed at edge k appears on out_* with out_valid=1 after edge k when the buffer was empty.
REQ-026 SHALL drive in_ready = not full from a register; it SHALL have no combinational dependence on out_ready.
REQ-027 SHALL, when full, refuse a push even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
REQ-028 SHALL, when neither empty nor full, accept a simultaneous push and pop: occupancy unchanged, order preserved.
REQ-029 SHALL, when empty, drive out_valid 0; out_imm, out_fmt and out_illegal are defined only while out_valid=1.
REQ-030 SHALL wrap read and write pointers modulo DEPTH; results leave in strict FIFO order.
REQ-031 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-032 SHALL increment ill_count on each push of an illegal instruction, saturating at 255.
REQ-033 SHALL give clr_cnt priority over increment: the count becomes 0 that edge even if an illegal push occurs.

Reset
REQ-034 SHALL, on reset_n=0 and without waiting for clk, empty the buffer and drive out_valid 0, in_ready 1 and ill_count 0.
REQ-035 SHALL discard buffered entries on reset mid-operation; the first push after reset_n rises yields out_valid after one edge.

Verification
REQ-036 SHALL cover: push 0xF85AAAAA (N=64) -> out_imm 0xFFFFFFFFFFFFFFAA, fmt 0, illegal 0, one cycle later.
REQ-037 SHALL cover: push 0xB4FF00FF -> out_imm 0xFFFFFFFFFFFFF807, fmt 1; with BR_SHIFT=1 -> out_imm 0xFFFFFFFFFFFFE01C.
REQ-038 SHALL cover: push 0xFFFFFFFF -> out_imm 0, fmt 7, illegal 1, ill_count 1; clr_cnt together with an illegal push -> ill_count 0.
REQ-039 SHALL cover: out_ready=0 with DEPTH=2 and three pushes offered -> in_ready 0 after the 2nd push, 3rd held; then out_ready=1 -> outputs in order, 3rd accepted one cycle after the first pop.
REQ-040 SHALL cover: 256 illegal pushes -> ill_count saturates at 255.
REQ-041 SHALL cover: reset_n low mid-stream with 2 entries buffered -> out_valid 0 and in_ready 1 immediately, ill_count 0.
